// File: rtl/raster_pkg.sv
// Shared types and helpers for the raster timing generator.
// The phase order is fixed so that the next phase is always the current phase + 1.
package raster_pkg;

  typedef enum logic [1:0] {
    PHASE_ACTIVE,
    PHASE_FP,
    PHASE_SYNC,
    PHASE_BP
  } phase_t;

  // Last counter index that belongs to the given phase.
  function automatic int unsigned phase_end(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp,
                                            input phase_t      phase);
    int unsigned r_end;
    case (phase)
      PHASE_ACTIVE: r_end = active - 1;
      PHASE_FP:     r_end = active + fp - 1;
      PHASE_SYNC:   r_end = active + fp + sync - 1;
      default:      r_end = active + fp + sync + bp - 1;
    endcase
    return r_end;
  endfunction

endpackage

// File: rtl/axis_timer3.sv
// One raster axis: a wrapping counter plus its four-phase sequencer.
// Used for both the horizontal (pixel) and vertical (line) axes.
module axis_timer3
  import raster_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
  localparam int unsigned CW    = $clog2(TOTAL)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          step,
  output logic [CW-1:0] count,
  output phase_t        phase,
  output logic          wrap
);

  logic [CW-1:0] r_count;
  phase_t        r_phase;
  logic          w_last;
  logic          w_phase_last;

  assign w_last       = (r_count == CW'(TOTAL - 1));
  assign w_phase_last = (r_count == CW'(phase_end(ACTIVE, FP, SYNC, BP, r_phase)));

  // The BP -> ACTIVE step coincides with the counter wrap, so +1 covers all cases.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_phase <= PHASE_ACTIVE;
    end else if (step) begin
      r_count <= w_last ? '0 : r_count + 1'b1;
      if (w_phase_last) begin
        r_phase <= phase_t'(r_phase + 2'd1);
      end
    end
  end

  assign count = r_count;
  assign phase = r_phase;
  assign wrap  = step && w_last;

endmodule

// File: rtl/raster_scan3.sv
// Parametrised raster timing generator: h/v axis timers, sync polarity, registered
// vsync aligned to hsync leading edges, line/frame pulses and a frame counter.
module raster_scan3
  import raster_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned LINE_LEAD  = 128,
  parameter int unsigned Y_SAT_BITS = 9,
  parameter int unsigned FRAME_BITS = 8,
  parameter bit          HSYNC_POL  = 1'b0,
  parameter bit          VSYNC_POL  = 1'b0,
  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned XW        = $clog2(H_TOTAL),
  localparam int unsigned YW        = $clog2(V_TOTAL)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic [XW-1:0]         x,
  output logic [YW-1:0]         y,
  output logic [Y_SAT_BITS-1:0] y_sat,
  output logic                  saturated,
  output logic                  h_active,
  output logic                  v_active,
  output logic                  active,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  line_prefetch,
  output logic                  new_line,
  output logic                  new_frame,
  output logic                  h_active_done,
  output logic [FRAME_BITS-1:0] frame
);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || LINE_LEAD < 1) begin : g_err_timing
    $error("raster_scan3: every timing parameter must be at least 1");
  end
  if (LINE_LEAD >= H_TOTAL) begin : g_err_lead
    $error("raster_scan3: LINE_LEAD must be below H_TOTAL");
  end
  if (Y_SAT_BITS > YW) begin : g_err_ysat
    $error("raster_scan3: Y_SAT_BITS must not exceed the y width");
  end

  logic [XW-1:0]         w_x;
  logic [YW-1:0]         w_y;
  phase_t                w_h_phase;
  phase_t                w_v_phase;
  logic                  w_h_wrap;
  logic                  w_v_wrap;
  logic                  w_hsync_enter;
  logic                  w_saturated;
  logic                  r_vsync;
  logic [FRAME_BITS-1:0] r_frame;

  axis_timer3 #(
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .BP    (H_BP)
  ) u_h_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .step   (enable),
    .count  (w_x),
    .phase  (w_h_phase),
    .wrap   (w_h_wrap)
  );

  axis_timer3 #(
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .BP    (V_BP)
  ) u_v_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .step   (w_h_wrap),
    .count  (w_y),
    .phase  (w_v_phase),
    .wrap   (w_v_wrap)
  );

  // Tick on which the h phase moves FP -> SYNC; vsync is sampled only here.
  assign w_hsync_enter = enable && (w_x == XW'(H_ACTIVE + H_FP - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vsync <= ~VSYNC_POL;
      r_frame <= '0;
    end else begin
      if (w_hsync_enter) begin
        r_vsync <= (w_v_phase == PHASE_SYNC) ? VSYNC_POL : ~VSYNC_POL;
      end
      if (w_v_wrap) begin
        r_frame <= r_frame + 1'b1;
      end
    end
  end

  if (Y_SAT_BITS < YW) begin : g_sat
    assign w_saturated = |w_y[YW-1:Y_SAT_BITS];
  end else begin : g_no_sat
    assign w_saturated = 1'b0;
  end

  assign x             = w_x;
  assign y             = w_y;
  assign saturated     = w_saturated;
  assign y_sat         = w_saturated ? '0 : w_y[Y_SAT_BITS-1:0];
  assign h_active      = (w_h_phase == PHASE_ACTIVE);
  assign v_active      = (w_v_phase == PHASE_ACTIVE);
  assign active        = h_active && v_active;
  assign hsync         = (w_h_phase == PHASE_SYNC) ? HSYNC_POL : ~HSYNC_POL;
  assign vsync         = r_vsync;
  assign new_line      = w_h_wrap;
  assign new_frame     = w_v_wrap;
  assign line_prefetch = enable && (w_x == XW'(H_TOTAL - 1 - LINE_LEAD));
  assign h_active_done = enable && (w_x == XW'(H_ACTIVE - 1));
  assign frame         = r_frame;

endmodule

// File: tb/tb_raster_scan3.sv
// Randomised bench for raster_scan3 with small timings; the reference derives every
// output from the number of accepted enable ticks since reset.
module tb_raster_scan3;

  localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int unsigned VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int unsigned LEAD = 4;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FT = HT * VT;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  logic [3:0] x, p_x;
  logic [2:0] y, p_y;
  logic [1:0] y_sat, p_y_sat;
  logic [7:0] frame, p_frame;
  logic saturated, h_active, v_active, active, hsync, vsync;
  logic line_prefetch, new_line, new_frame, h_active_done;
  logic p_saturated, p_h_active, p_v_active, p_active, p_hsync, p_vsync;
  logic p_line_prefetch, p_new_line, p_new_frame, p_h_active_done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned t = 0;

  always #5 clk = ~clk;

  raster_scan3 #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LINE_LEAD(LEAD), .Y_SAT_BITS(2), .FRAME_BITS(8),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) u_dut (
    .clk(clk), .reset_n(rst_n), .enable(en),
    .x(x), .y(y), .y_sat(y_sat), .saturated(saturated),
    .h_active(h_active), .v_active(v_active), .active(active),
    .hsync(hsync), .vsync(vsync), .line_prefetch(line_prefetch),
    .new_line(new_line), .new_frame(new_frame), .h_active_done(h_active_done),
    .frame(frame)
  );

  raster_scan3 #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LINE_LEAD(LEAD), .Y_SAT_BITS(2), .FRAME_BITS(8),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_dut_pos (
    .clk(clk), .reset_n(rst_n), .enable(en),
    .x(p_x), .y(p_y), .y_sat(p_y_sat), .saturated(p_saturated),
    .h_active(p_h_active), .v_active(p_v_active), .active(p_active),
    .hsync(p_hsync), .vsync(p_vsync), .line_prefetch(p_line_prefetch),
    .new_line(p_new_line), .new_frame(p_new_frame), .h_active_done(p_h_active_done),
    .frame(p_frame)
  );

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (tick %0d, t=%0t)", tag, obs, exp, t, $time);
    end
  endtask

  task automatic check_all();
    int unsigned xm, ym, fm, lm;
    bit in_hs, vs_act, e;
    e  = en && rst_n;
    xm = t % HT;
    ym = (t / HT) % VT;
    fm = (t / FT) % 256;
    in_hs = (xm >= HA + HF) && (xm < HA + HF + HS);
    // vsync changes at the hsync leading edge, i.e. HA+HF ticks into each line.
    vs_act = 1'b0;
    if (t >= HA + HF) begin
      lm = ((t - (HA + HF)) / HT) % VT;
      vs_act = (lm >= VA + VF) && (lm < VA + VF + VS);
    end
    check("x", x, xm);
    check("y", y, ym);
    check("y_sat", y_sat, (ym < 4) ? ym : 0);
    check("saturated", saturated, ym >= 4);
    check("h_active", h_active, xm < HA);
    check("v_active", v_active, ym < VA);
    check("active", active, (xm < HA) && (ym < VA));
    check("hsync", hsync, !in_hs);
    check("vsync", vsync, !vs_act);
    check("line_prefetch", line_prefetch, e && (xm == HT - 1 - LEAD));
    check("new_line", new_line, e && (xm == HT - 1));
    check("new_frame", new_frame, e && (xm == HT - 1) && (ym == VT - 1));
    check("h_active_done", h_active_done, e && (xm == HA - 1));
    check("frame", frame, fm);
    check("pos_hsync", p_hsync, in_hs);
    check("pos_vsync", p_vsync, vs_act);
    check("pos_x", p_x, xm);
    check("pos_frame", p_frame, fm);
  endtask

  // Drive enable just after an edge, check mid-cycle, then advance the model on the edge.
  task automatic cycle(input bit e);
    en = e;
    #1;
    check_all();
    @(posedge clk);
    if (e && rst_n) t++;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    en = 1'b1;
    #1;
    check_all();
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 2 * FT; i++) cycle(1'b1);
    for (int i = 0; i < 40; i++) cycle(i % 2 == 0);
    for (int i = 0; i < 3 * FT; i++) cycle($urandom_range(3, 0) != 0);
    for (int i = 0; i < 200; i++) cycle($urandom_range(1, 0) == 1);

    // Bring the scan to x=11, y=5 (vsync active), then reset between edges.
    for (int i = 0; i < 2 * FT && (t % FT) != (5 * HT + 11); i++) cycle($urandom_range(1, 0) == 1);
    check("reach_x11_y5", t % FT, 5 * HT + 11);
    en = 1'b1;
    #1;
    check_all();
    check("vsync_before_reset", vsync, 0);
    #1;
    rst_n = 1'b0;
    t     = 0;
    #1;
    check_all();
    check("vsync_in_reset", vsync, 1);
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 256 * FT + 2 * HT; i++) cycle(1'b1);
    check("frames_wrapped", frame, 0);
    for (int i = 0; i < 300; i++) cycle($urandom_range(2, 0) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/raster_scan3.md
Name: raster_scan3

Overview:
- Fully parametrised VGA-style raster timing generator: horizontal and vertical counters, four-phase (active/front porch/sync/back porch) sequencing, sync polarity selection, early line-prefetch pulse and a frame counter.
- Sits between the pixel-clock enable and the per-pixel renderers; it is the next generation of the fixed 640x480 scan generator, with every timing a parameter.
- Every state register, including the phase registers, is reset.

Parameters:
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- LINE_LEAD, 128: number of pixel ticks before line wrap at which `line_prefetch` pulses. Range is 1..H_TOTAL-1.
- Y_SAT_BITS, 9: width of the saturating y output.
- FRAME_BITS, 8: width of the frame counter.
- HSYNC_POL, 0: active level of hsync (0 = negative).
- VSYNC_POL, 0: active level of vsync (0 = negative).

Ports:
- clk  in  1  pixel-domain clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  pixel tick; all counters advance only when high.
- x  out  XW  horizontal count 0..H_TOTAL-1; 0 = first visible pixel. XW = $clog2(H_TOTAL).
- y  out  YW  vertical count 0..V_TOTAL-1; 0 = first visible line. YW = $clog2(V_TOTAL).
- y_sat  out  Y_SAT_BITS  equals y, or 0 when `saturated` is high.
- saturated  out  1  high when y >= 2**Y_SAT_BITS.
- h_active  out  1  horizontal phase is ACTIVE.
- v_active  out  1  vertical phase is ACTIVE.
- active  out  1  h_active && v_active.
- hsync  out  1  horizontal sync, at polarity HSYNC_POL.
- vsync  out  1  vertical sync, at polarity VSYNC_POL.
- line_prefetch  out  1  one-tick pulse LINE_LEAD ticks before line wrap.
- new_line  out  1  one-tick pulse on line wrap.
- new_frame  out  1  one-tick pulse on frame wrap.
- h_active_done  out  1  one-tick pulse on the last visible pixel.
- frame  out  FRAME_BITS  frame counter, wraps modulo 2**FRAME_BITS.

Behaviour:
- Totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL is the vertical equivalent.
- Reset (reset_n low, asynchronous):
  - x = 0, y = 0, both phases = ACTIVE, frame = 0.
  - Registered vsync at its inactive level; hsync inactive (it follows the phase, which is ACTIVE).
  - All pulse outputs 0.
  - After reset release, the first enable tick is therefore the first pixel of line 0 of frame 0.
- enable low: every register holds; pulse outputs are 0.
- Horizontal counter, on an enable tick:
  - x increments; at x == H_TOTAL-1, x wraps to 0 and `h_wrap` = enable && x == H_TOTAL-1.
  - h phase advances ACTIVE→FP→SYNC→BP→ACTIVE on the enable tick where x equals the last index of the current phase: H_ACTIVE-1, H_ACTIVE+H_FP-1, H_ACTIVE+H_FP+H_SYNC-1, H_TOTAL-1.
  - The phase update and the x update occur on the same edge.
- Vertical counter:
  - Advances only when h_wrap is high, using the same phase rule against V_* boundaries.
  - Wraps at V_TOTAL-1.
- Combinational pulses, each qualified by enable:
  - new_line = h_wrap.
  - new_frame = h_wrap && y == V_TOTAL-1.
  - line_prefetch = enable && x == H_TOTAL-1-LINE_LEAD.
  - h_active_done = enable && x == H_ACTIVE-1.
- Sync outputs:
  - hsync is combinational from the h phase register: hsync = (h phase == SYNC) ? HSYNC_POL : !HSYNC_POL.
  - The internal vsync level is sampled into a register only on the tick where the h phase enters SYNC, so vsync edges coincide with hsync leading edges.
- frame increments on new_frame and wraps silently.
- y_sat / saturated are combinational from y.
- Simultaneous events at x = H_TOTAL-1, y = V_TOTAL-1: x, y, both phases and frame all update on the same edge; the next state is x = 0, y = 0, phases ACTIVE.
- Reset mid-line or mid-frame: immediate return to the reset state; no partial pulses are produced.
- Elaboration errors ($error):
  - any timing parameter < 1;
  - LINE_LEAD >= H_TOTAL;
  - Y_SAT_BITS > YW.

Decomposition:
- Package raster_pkg:
  - typedef enum logic [1:0] phase_t {PHASE_ACTIVE, PHASE_FP, PHASE_SYNC, PHASE_BP}. Order is fixed; the phase advances by +1.
  - Function phase_end(active, fp, sync, bp, phase) returning the last index of that phase.
- Sub-module axis_timer3:
  - Parameters ACTIVE, FP, SYNC, BP.
  - Ports clk, reset_n, step → count, phase, wrap.
  - Instantiated twice: horizontal with step = enable, vertical with step = h_wrap.
- The top level adds the pulse logic, sync polarity, the registered vsync, frame and y_sat.

Test Plan:
All scenarios use small timings: H = 8/2/3/3 (H_TOTAL 16), V = 4/1/2/1 (V_TOTAL 8), LINE_LEAD = 4, Y_SAT_BITS = 2.

1. Reset release, enable held high: x counts 0..15 then 0. h_active is high for x 0..7. hsync is low for x 10..12 and high otherwise. new_line pulses at x = 15 only. line_prefetch pulses at x = 11. h_active_done pulses at x = 7.
2. Run a full frame (128 ticks): y steps 0..7. v_active is high for y 0..3. vsync goes low at the hsync leading edge (x = 10) of y = 5 and returns high at the x = 10 edge of y = 7. new_frame pulses once, at x = 15, y = 7, and frame goes 0→1.
3. enable toggled 1-0-1 for 40 ticks: the outputs equal scenario 1's sequence with the hold cycles inserted. No pulse is high while enable = 0.
4. y_sat / saturated: y = 3 gives y_sat = 3, saturated = 0. y = 4..7 gives y_sat = 0, saturated = 1.
5. Assert reset_n low at x = 11, y = 5 (vsync active), between clock edges: all outputs immediately take their reset values (vsync high, x = 0, y = 0, frame = 0). After release, the timing of scenario 1 repeats exactly.
6. Run 256 frames with FRAME_BITS = 8: frame wraps 255→0 on new_frame. Polarity variant HSYNC_POL = 1: hsync is high only for x 10..12.
